// File: rtl/glyph_string_drawer.sv
// glyph_string_drawer: scans every pixel of a latched string of glyphs and issues clipped plot requests
module glyph_string_drawer #(
    parameter int GLYPH_W   = 8,
    parameter int GLYPH_H   = 10,
    parameter int MAX_CHARS = 8,
    parameter int CODE_W    = 6,
    parameter int COLOUR_W  = 6,
    parameter int SPACING   = 1,
    parameter int SCREEN_W  = 160,
    parameter int SCREEN_H  = 120,
    localparam int NW = $clog2(MAX_CHARS + 1),
    localparam int CW = MAX_CHARS > 1 ? $clog2(MAX_CHARS) : 1,
    localparam int RW = GLYPH_H > 1 ? $clog2(GLYPH_H) : 1,
    localparam int XW = GLYPH_W > 1 ? $clog2(GLYPH_W) : 1
) (
    input  logic                          clock,
    input  logic                          resetn,
    input  logic                          start,
    input  logic [7:0]                    origin_x,
    input  logic [7:0]                    origin_y,
    input  logic [NW-1:0]                 num_chars,
    input  logic [MAX_CHARS*CODE_W-1:0]   codes,
    input  logic [COLOUR_W-1:0]           fg_colour,
    input  logic [COLOUR_W-1:0]           bg_colour,
    input  logic                          opaque,
    output logic [CODE_W-1:0]             font_code,
    output logic [RW-1:0]                 font_row,
    input  logic [GLYPH_W-1:0]            font_bits,
    output logic [7:0]                    plot_x,
    output logic [7:0]                    plot_y,
    output logic [COLOUR_W-1:0]           plot_colour,
    output logic                          plot_valid,
    input  logic                          plot_ready,
    output logic                          busy,
    output logic                          done
);
    typedef enum logic [1:0] {IDLE, DRAW, DONE} state_t;
    state_t state, state_next;
    logic [CW-1:0] ch;
    logic [RW-1:0] row;
    logic [XW-1:0] col;
    logic [NW-1:0] n_lat, n_clamp;
    logic [7:0] ox, oy;
    logic [MAX_CHARS*CODE_W-1:0] codes_lat;
    logic [COLOUR_W-1:0] fg, bg;
    logic op;
    logic [15:0] px, py;
    logic pix, drawable, last, advance;

    always_ff @(posedge clock)
        state <= !resetn ? IDLE : state_next;

    always_ff @(posedge clock) begin
        if (!resetn) begin
            ch <= '0;
            row <= '0;
            col <= '0;
            n_lat <= '0;
            ox <= '0;
            oy <= '0;
            codes_lat <= '0;
            fg <= '0;
            bg <= '0;
            op <= 1'b0;
        end else if (state == IDLE && start) begin
            ch <= '0;
            row <= '0;
            col <= '0;
            n_lat <= n_clamp;
            ox <= origin_x;
            oy <= origin_y;
            codes_lat <= codes;
            fg <= fg_colour;
            bg <= bg_colour;
            op <= opaque;
        end else if (advance) begin
            col <= col == XW'(GLYPH_W - 1) ? '0 : col + XW'(1);
            if (col == XW'(GLYPH_W - 1)) begin
                row <= row == RW'(GLYPH_H - 1) ? '0 : row + RW'(1);
                if (row == RW'(GLYPH_H - 1))
                    ch <= ch + CW'(1);
            end
        end
    end

    always_comb begin
        n_clamp = num_chars > NW'(MAX_CHARS) ? NW'(MAX_CHARS) : num_chars;
        state_next = state == IDLE ? (start ? (n_clamp == '0 ? DONE : DRAW) : IDLE) :
                     state == DRAW ? (advance && last ? DONE : DRAW) : IDLE;
    end

    // Wide px/py so positions past 255 fail the screen bounds instead of wrapping.
    always_comb begin
        px = 16'(ox) + 16'(ch) * 16'(GLYPH_W + SPACING) + 16'(col);
        py = 16'(oy) + 16'(row);
        pix = font_bits[XW'(GLYPH_W - 1) - col];
        drawable = (pix || op) && px < 16'(SCREEN_W) && py < 16'(SCREEN_H);
        last = NW'(ch) == n_lat - NW'(1) && row == RW'(GLYPH_H - 1) && col == XW'(GLYPH_W - 1);
        busy = state == DRAW;
        done = state == DONE;
        advance = busy && (!drawable || plot_ready);
        plot_valid = busy && drawable;
        plot_x = busy ? px[7:0] : '0;
        plot_y = busy ? py[7:0] : '0;
        plot_colour = busy ? (pix ? fg : bg) : '0;
        font_code = busy ? codes_lat[ch*CODE_W +: CODE_W] : '0;
        font_row = busy ? row : '0;
    end
endmodule

// File: tb/tb_glyph_string_drawer.sv
// tb_glyph_string_drawer: directed checks of glyph_string_drawer against hand-derived pixel streams
module tb_glyph_string_drawer;
    logic clock = 0, resetn = 0, start = 0, opaque = 0, plot_ready = 0;
    logic [7:0] origin_x = 0, origin_y = 0;
    logic [3:0] num_chars = 0;
    logic [47:0] codes = 0;
    logic [5:0] fg_colour = 0, bg_colour = 0, font_code, plot_colour;
    logic [3:0] font_row;
    logic [7:0] font_bits, plot_x, plot_y;
    logic plot_valid, busy, done;
    int checks = 0, errors = 0;

    always #5 clock = ~clock;

    glyph_string_drawer dut (
        .clock(clock), .resetn(resetn), .start(start),
        .origin_x(origin_x), .origin_y(origin_y), .num_chars(num_chars), .codes(codes),
        .fg_colour(fg_colour), .bg_colour(bg_colour), .opaque(opaque),
        .font_code(font_code), .font_row(font_row), .font_bits(font_bits),
        .plot_x(plot_x), .plot_y(plot_y), .plot_colour(plot_colour),
        .plot_valid(plot_valid), .plot_ready(plot_ready), .busy(busy), .done(done)
    );

    // Font ROM: 1 = stripes (even rows set), 2 = solid, 3 = row-dependent pattern
    function automatic logic [7:0] rom(input logic [5:0] c, input logic [3:0] r);
        return c == 6'd1 ? (r[0] ? 8'h00 : 8'hFF) : c == 6'd2 ? 8'hFF : c == 6'd3 ? (8'hA5 ^ {r, r}) : 8'h00;
    endfunction

    always_comb font_bits = rom(font_code, font_row);

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clock);
        #1;
    endtask

    // Launch a string, then scramble the inputs to prove they were latched
    task automatic go(input logic [7:0] ox, input logic [7:0] oy, input logic [3:0] n,
                      input logic [47:0] cd, input logic [5:0] fg, input logic [5:0] bg, input logic op);
        origin_x = ox; origin_y = oy; num_chars = n; codes = cd;
        fg_colour = fg; bg_colour = bg; opaque = op; start = 1;
        tick();
        start = 0; origin_x = 8'hEE; origin_y = 8'hEE; num_chars = 4'd5; codes = '1;
        fg_colour = 6'h00; bg_colour = 6'h07; opaque = ~op;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic [21:0] exp_q[$];
        logic [21:0] hv, e;
        logic held, ev;
        int plots, k, x;
        logic [7:0] lastx;

        resetn = 0;
        tick(); tick();
        check("reset_outs", {plot_valid, busy, done, plot_x, plot_y, plot_colour, font_code, font_row}, 64'd0);
        resetn = 1;
        tick();
        check("idle_outs", {plot_valid, busy, done, plot_x, plot_y, plot_colour, font_code, font_row}, 64'd0);

        // opaque stripes
        plot_ready = 1;
        go(8'd10, 8'd20, 4'd1, 48'd1, 6'h3F, 6'h15, 1'b1);
        for (int i = 0; i < 80; i++) begin
            check("t1_pix", {plot_valid, busy, done, plot_x, plot_y, plot_colour, font_code, font_row},
                  {3'b110, 8'(10 + i % 8), 8'(20 + i / 8), ((i / 8) % 2) ? 6'h15 : 6'h3F, 6'd1, 4'(i / 8)});
            tick();
        end
        check("t1_done", {busy, done, plot_valid}, 3'b010);
        tick();
        check("t1_idle", {busy, done, plot_valid}, 3'b000);

        // transparent stripes
        go(8'd10, 8'd20, 4'd1, 48'd1, 6'h3F, 6'h15, 1'b0);
        plots = 0;
        for (int i = 0; i < 80; i++) begin
            ev = ((i / 8) % 2) == 0;
            check("t2_state", {plot_valid, busy, done}, {ev, 2'b10});
            if (plot_valid) begin
                plots++;
                check("t2_pix", {plot_x, plot_y, plot_colour}, {8'(10 + i % 8), 8'(20 + i / 8), 6'h3F});
            end
            tick();
        end
        check("t2_count", plots, 40);
        check("t2_done", {busy, done}, 2'b01);
        tick();

        // backpressure with a reference pixel queue, chars 3 then 1, transparent
        for (int c = 0; c < 2; c++)
            for (int r = 0; r < 10; r++)
                for (int cl = 0; cl < 8; cl++) begin
                    e[7:0] = rom(c == 0 ? 6'd3 : 6'd1, 4'(r));
                    if (e[7 - cl]) exp_q.push_back({8'(40 + c * 9 + cl), 8'(50 + r), 6'h2A});
                end
        go(8'd40, 8'd50, 4'd2, 48'h43, 6'h2A, 6'h11, 1'b0);
        held = 0; hv = 0; k = 0;
        while (!done && k < 2000) begin
            plot_ready = (k % 3) == 0;
            if (held) check("t3_hold", {plot_valid, plot_x, plot_y, plot_colour}, {1'b1, hv});
            if (plot_valid && plot_ready) begin
                if (exp_q.size() > 0) e = exp_q.pop_front();
                else e = '1;
                check("t3_order", {plot_x, plot_y, plot_colour}, e);
                held = 0;
            end else begin
                held = plot_valid;
                hv = {plot_x, plot_y, plot_colour};
            end
            tick();
            k++;
        end
        check("t3_left", exp_q.size(), 0);
        check("t3_done", done, 1'b1);
        plot_ready = 1;
        tick();

        // three solid chars running off the right edge
        go(8'd150, 8'd5, 4'd3, 48'h2082, 6'h30, 6'h0C, 1'b0);
        plots = 0;
        for (int i = 0; i < 240; i++) begin
            x = 150 + (i / 80) * 9 + i % 8;
            check("t4_valid", {plot_valid, busy}, {x < 160, 1'b1});
            if (plot_valid) begin
                plots++;
                check("t4_pix", {plot_x, plot_y, plot_colour}, {8'(x), 8'(5 + (i % 80) / 8), 6'h30});
            end
            tick();
        end
        check("t4_count", plots, 90);
        check("t4_done", {busy, done}, 2'b01);
        tick();

        // empty string
        go(8'd0, 8'd0, 4'd0, 48'd2, 6'h01, 6'h02, 1'b1);
        check("t5_done", {done, busy, plot_valid}, 3'b100);
        tick();
        check("t5_idle", {done, busy, plot_valid}, 3'b000);

        // over-long string clamps to eight glyphs; a start mid-draw is ignored
        go(8'd0, 8'd0, 4'd15, 48'h082082082082, 6'h01, 6'h02, 1'b1);
        plots = 0; k = 0; lastx = 0;
        while (!done && k < 2000) begin
            if (k == 100) begin
                start = 1; num_chars = 4'd1; origin_x = 8'd90;
            end
            if (k == 101) start = 0;
            if (plot_valid) begin
                plots++;
                lastx = plot_x;
            end
            tick();
            k++;
        end
        check("t6_count", plots, 640);
        check("t6_cycles", k, 640);
        check("t6_lastx", lastx, 8'd70);
        tick();
        check("t6_idle", {busy, done}, 2'b00);
        tick();
        check("t6_no_queue", {busy, done}, 2'b00);

        // reset while a plot is stalled
        plot_ready = 0;
        go(8'd20, 8'd30, 4'd1, 48'd1, 6'h3F, 6'h15, 1'b1);
        tick(); tick();
        check("t7_stall", {plot_valid, busy, plot_x, plot_y}, {2'b11, 8'd20, 8'd30});
        resetn = 0;
        tick();
        check("t7_reset", {plot_valid, busy, done, plot_x, plot_y, plot_colour, font_code, font_row}, 64'd0);
        resetn = 1;
        tick();
        check("t7_no_done", {plot_valid, busy, done}, 3'b000);
        plot_ready = 1;
        go(8'd30, 8'd40, 4'd1, 48'd1, 6'h3F, 6'h15, 1'b1);
        check("t7_first", {plot_valid, plot_x, plot_y, plot_colour, font_row}, {1'b1, 8'd30, 8'd40, 6'h3F, 4'd0});
        tick();
        check("t7_second", {plot_valid, plot_x, plot_y}, {1'b1, 8'd31, 8'd40});

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/glyph_string_drawer.md
Name: glyph_string_drawer

Overview:
Sequential text renderer that draws a string of up to MAX_CHARS glyphs into the frame-buffer plotter. It replaces the per-character combinational glyph matchers. The glyph bitmap comes from an external combinational font ROM, queried one row at a time. The block walks every pixel of every glyph and emits plot requests over a valid/ready handshake, with foreground/background colouring, an opaque/transparent mode and screen-edge clipping. It sits between game-state logic (score, "GAME OVER" banners) and the shared VGA plot arbiter.

Parameters:
GLYPH_W, 8, glyph width in pixels (columns 0..GLYPH_W-1)
GLYPH_H, 10, glyph height in pixels (rows 0..GLYPH_H-1)
MAX_CHARS, 8, maximum string length
CODE_W, 6, character code width
COLOUR_W, 6, colour width (2 bits per RGB channel)
SPACING, 1, blank pixel columns between adjacent glyphs (x offset only; never plotted)
SCREEN_W, 160, pixels with x >= SCREEN_W are clipped
SCREEN_H, 120, pixels with y >= SCREEN_H are clipped

Ports:
clock  in  1  system clock; all state on rising edge
resetn  in  1  synchronous active-low reset
start  in  1  begin drawing; sampled only in IDLE
origin_x  in  8  top-left x of the first glyph
origin_y  in  8  top-left y of the first glyph
num_chars  in  clog2(MAX_CHARS+1)  string length
codes  in  MAX_CHARS*CODE_W  char i at bits [i*CODE_W +: CODE_W]; char 0 is leftmost
fg_colour  in  COLOUR_W  colour for set glyph bits
bg_colour  in  COLOUR_W  colour for clear bits (opaque mode only)
opaque  in  1  1 = also plot clear bits in bg_colour; 0 = skip them
font_code  out  CODE_W  code of the current character to the font ROM
font_row  out  clog2(GLYPH_H)  current glyph row to the font ROM
font_bits  in  GLYPH_W  combinational ROM row; bit GLYPH_W-1 = column 0 (leftmost)
plot_x  out  8  pixel x
plot_y  out  8  pixel y
plot_colour  out  COLOUR_W  pixel colour
plot_valid  out  1  plot request
plot_ready  in  1  plotter accepts when valid && ready at the clock edge
busy  out  1  high while in DRAW
done  out  1  one-cycle completion pulse

Behaviour:
- Clock and reset: a single clock, `clock`. Reset is synchronous and active-low on `resetn`.
- Reset values: state = IDLE; all counters = 0; plot_valid = 0, busy = 0, done = 0; plot_x, plot_y, plot_colour = 0; font_code and font_row = 0.
- Reset mid-DRAW aborts the string immediately; plot_valid is 0 in the cycle after the reset edge. No done pulse is generated.
- FSM states: IDLE, DRAW, DONE.
- IDLE -> DRAW: when start = 1 at an edge and the clamped num_chars > 0.
  - At that edge, latch origin_x, origin_y, codes, fg_colour, bg_colour and opaque.
  - Latch num_chars clamped to MAX_CHARS.
  - Clear the counters (char, row, col).
  - Later input changes have no effect until the next start.
- IDLE -> DONE: when start = 1 and num_chars = 0. No plots are issued.
- start while in DRAW or DONE is ignored. It is not queued.
- DRAW, scan order: char outer, row middle, col inner; col increments first.
- DRAW, combinational outputs from the latched values and counters:
  - font_code = code[char]; font_row = row.
  - px = origin_x + char*(GLYPH_W+SPACING) + col, computed at 9+ bits.
  - py = origin_y + row, computed at 9+ bits.
  - plot_x = px[7:0]; plot_y = py[7:0].
  - bit = font_bits[GLYPH_W-1-col].
- DRAW, pixel is drawable iff (bit || opaque) && px < SCREEN_W && py < SCREEN_H.
- DRAW, plot_colour = fg_colour if bit, else bg_colour.
- DRAW, plot_valid = drawable.
- DRAW, advance rule:
  - Drawable pixel: advance only on an edge with plot_ready = 1. While waiting, plot_x, plot_y and plot_colour are held stable.
  - Non-drawable pixel (skipped or clipped): advance unconditionally, costing 1 cycle with plot_valid = 0.
- Last-pixel rule: when advancing from char = n-1, row = GLYPH_H-1, col = GLYPH_W-1, go to DONE.
- DONE: done = 1 for exactly one cycle, then IDLE.
- busy = 1 exactly when state = DRAW.
- Outside DRAW: plot_valid = 0.
- Latency with plot_ready held at 1 and no skips:
  - start sampled at edge 0.
  - The first pixel is presented in cycle 1.
  - The pixel count is P = n*GLYPH_W*GLYPH_H, presented in cycles 1..P.
  - done is high in cycle P+1.
- Overflow: px/py beyond 255 are clipped by the SCREEN bounds, so no wrapped pixel is ever plotted.

Test Plan:
- Opaque, all pixels: origin (10,20), n=1, glyph rows alternating 0xFF/0x00, ready held at 1, opaque=1 -> exactly 80 plots in cycles 1..80 with x 10..17 and y 20..29. Rows with even index are fg and odd rows are bg. done pulses in cycle 81; busy is high in cycles 1..80.
- Transparent mode: same glyph, opaque=0 -> 40 plots, all fg, all on even rows. The drawing still takes 80 DRAW cycles; done in cycle 81.
- Backpressure: plot_ready toggling 1,0,0,1... -> each plot held stable until accepted. There are no duplicate or dropped pixels; the order matches a reference model.
- Multi-char and clipping: n=3, origin_x=150, all-ones glyph, opaque=0.
  - Char 0 is plotted at x 150..157.
  - Char 1 is plotted at x 159 only, since x 160..167 are clipped.
  - Char 2 (x 168..175) is fully clipped.
  - done still pulses.
- Edge cases:
  - n=0 -> done pulses in cycle 1 and plot_valid is never high.
  - n=15 with MAX_CHARS=8 -> exactly 8 glyphs are drawn.
  - start pulsed during DRAW is ignored.
- Reset mid-DRAW: resetn=0 for one edge while plot_valid is waiting -> the next cycle has plot_valid=0, busy=0, done=0. A fresh start then draws normally from char 0.
